stereo_scan_mixer_dac: RTL and testbench
========================================

Name: stereo_scan_mixer_dac

Overview:
- Parametrised N-channel stereo mixer with per-channel pan and attenuation registers, a fixed-period round-robin accumulator, a saturating output stage, and two embedded first-order sigma-delta DACs (left and right).
- Sits between the sound sources (PSG channels, beeper, Specdrum) and the audio output pins.
- Successor to the fixed 4-source panner/mixer: adds arbitrary channel count, per-channel attenuation, saturation with clip flags, and a deterministic frame period.

Parameters:
- NCH, 8, number of input channels (2..16).
- IW, 8, unsigned sample width per channel.
- OW, 10, mixed sample width and DAC input width.
- CFG_RST, 8'hC0, reset value of every channel config register (both sides, no attenuation).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  4  channel index for config read and write.
- cfg_din  in  8  config data. [7]=left enable, [6]=right enable, [5:4]=right-shift attenuation 0..3, [3:0] ignored (stored as 0).
- cfg_dout  out  8  config register of cfg_ch (combinational).
- samples  in  NCH*IW  flattened unsigned samples; channel k is bits [k*IW +: IW].
- clip_clr  in  1  clears the sticky clip flags.
- mix_left  out  OW  latched left mix.
- mix_right  out  OW  latched right mix.
- frame_strobe  out  1  one-cycle pulse when mix_left/mix_right update.
- clip_left  out  1  sticky left saturation flag.
- clip_right  out  1  sticky right saturation flag.
- dac_left  out  1  left sigma-delta bitstream.
- dac_right  out  1  right sigma-delta bitstream.

Behaviour:
- **Config registers**
  - cfg_we=1 with cfg_ch<NCH writes {cfg_din[7:4],4'b0}.
  - cfg_ch>=NCH: writes ignored, cfg_dout reads 0.
  - A write takes effect from the next clk edge. A scan cycle for channel k in the same cycle as a write to k uses the old value.
- **Scan**
  - Counter idx runs 0..NCH-1, advancing every clk, then wraps to 0.
  - Frame period is exactly NCH cycles, regardless of pan settings.
  - Term: t = samples[idx] >> atten[idx].
  - acc_l += left_en ? t : 0, and likewise for acc_r.
  - Accumulator width is IW+5 bits; it never overflows for NCH<=16.
- **End of frame** (the cycle with idx==NCH-1):
  - Final sum s = acc + t, computed per side.
  - mix <= (s > 2^OW-1) ? all-ones : s[OW-1:0].
  - On saturation, the corresponding clip flag sets.
  - acc <= 0.
  - frame_strobe <= 1 on the same edge, so it is high for the one following cycle, concurrent with the new mix value.
- **Sampling latency**: channel k is sampled in scan cycle k. Its contribution is visible on mix after NCH-k cycles.
- **Clip flags**
  - clip_clr clears both flags.
  - If clip_clr coincides with a saturating end-of-frame, the flag ends set (set wins).
- **DAC** (per side, first-order sigma-delta)
  - Input: mix, unsigned OW bits, held between strobes.
  - Integrator width OW+2.
  - Each cycle: integ <= integ + mix + ({2{integ[OW+1]}} << OW); dac <= integ[OW+1].
  - Long-run ones density = mix / 2^OW.
  - mix=0 gives constant 0 after settling. All-ones gives density (2^OW-1)/2^OW.
- **Reset** (synchronous, any time, including mid-frame):
  - idx=0, acc_l=acc_r=0.
  - mix_left=mix_right=0, frame_strobe=0.
  - clip flags 0, dac_left=dac_right=0.
  - Integrators = 1<<OW.
  - All config registers = CFG_RST.
  - The first frame_strobe after reset release occurs NCH cycles after release.
- **Simultaneous events**: a config write to the channel being scanned in the end-of-frame cycle does not affect that frame's result.

Test Plan:
- **Single channel, left only.** NCH=8. Ch0 cfg=8'h80, all samples 0 except ch0=100. → Each frame: mix_left=100, mix_right=0, frame_strobe every 8 cycles, no clip.
- **Attenuation.** Ch3 cfg=8'hE0 (both sides, shift 2), ch3=200, others muted (cfg=0). → mix_left=mix_right=50.
- **Saturation.** All 8 channels 255, cfg=CFG_RST. → Sum 2040 clamps: mix_left=mix_right=1023, clip_left=clip_right=1. Then clip_clr pulse with samples 0 → flags 0, next mix=0. clip_clr in a saturating end-of-frame cycle → flag remains 1.
- **Write collision.** Write ch7 cfg=0 in the cycle idx==7 with ch7=40, others 0. → That frame mix=40; the following frame mix=0. Readback cfg_dout=8'h00.
- **DAC density.** Hold mix_left=256 (OW=10). → Exactly 256 ones on dac_left in any 1024-cycle window after the first strobe plus 2 cycles. mix_left=0 → dac_left constant 0.
- **Mid-frame reset.** Assert reset at idx=4 with all outputs nonzero. → Next cycle all outputs 0, config = 8'hC0. First frame_strobe 8 cycles after release, with the full sum of all 8 channels.

Source files
------------

// File: rtl/stereo_scan_mixer_dac.sv
`default_nettype none
// ============================================================================
//  Module      : stereo_scan_mixer_dac
//  Description : N-channel stereo mixer. Per-channel pan/attenuation
//                registers, a fixed-period round-robin accumulator, a
//                saturating output stage with sticky clip flags, and one
//                first-order sigma-delta DAC per side.
//  Revision    : 1.0 - initial release
// ============================================================================
module stereo_scan_mixer_dac #(
  parameter int         NCH     = 8,
  parameter int         IW      = 8,
  parameter int         OW      = 10,
  parameter logic [7:0] CFG_RST = 8'hC0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [7:0]        cfg_din,
  output logic [7:0]        cfg_dout,
  input  logic [NCH*IW-1:0] samples,
  input  logic              clip_clr,
  output logic [OW-1:0]     mix_left,
  output logic [OW-1:0]     mix_right,
  output logic              frame_strobe,
  output logic              clip_left,
  output logic              clip_right,
  output logic              dac_left,
  output logic              dac_right
);

  localparam int C_IDXW = $clog2(NCH);
  localparam int C_ACCW = IW + 5;
  // Sum width must hold the accumulator and be wider than OW so that the
  // saturation compare is meaningful whatever the parameter mix.
  localparam int C_SUMW = (C_ACCW > OW) ? C_ACCW : OW + 1;
  localparam int C_DW   = OW + 2;

  localparam logic [C_IDXW-1:0] C_LAST      = C_IDXW'(NCH - 1);
  localparam logic [C_SUMW-1:0] C_MAXV      = {{(C_SUMW - OW){1'b0}}, {OW{1'b1}}};
  localparam logic [C_DW-1:0]   C_INTEG_RST = {2'b01, {OW{1'b0}}};

  // Stored nibble per channel: [3]=left enable, [2]=right enable, [1:0]=shift.
  logic [3:0]        r_cfg [NCH];
  logic [C_IDXW-1:0] r_idx;
  logic [C_ACCW-1:0] r_acc_l, r_acc_r;
  logic [C_DW-1:0]   r_integ_l, r_integ_r;

  logic [IW-1:0]     w_smp, w_term, w_add_l, w_add_r;
  logic [3:0]        w_cfg_cur;
  logic [C_SUMW-1:0] w_sum_l, w_sum_r;
  logic              w_last, w_sat_l, w_sat_r;

  // The low nibble of cfg_din is deliberately discarded.
  logic w_unused_ok;
  assign w_unused_ok = ^cfg_din[3:0];

  // Config register file; out-of-range channel indices match nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) r_cfg[k] <= CFG_RST[7:4];
    end else if (cfg_we) begin
      for (int k = 0; k < NCH; k++)
        if (cfg_ch == 4'(k)) r_cfg[k] <= cfg_din[7:4];
    end
  end

  // Combinational readback; unmatched index reads zero.
  always_comb begin
    cfg_dout = '0;
    for (int k = 0; k < NCH; k++)
      if (cfg_ch == 4'(k)) cfg_dout = {r_cfg[k], 4'b0000};
  end

  // Select the sample and config of the channel being scanned this cycle.
  always_comb begin
    w_smp     = '0;
    w_cfg_cur = '0;
    for (int k = 0; k < NCH; k++) begin
      if (r_idx == C_IDXW'(k)) begin
        w_smp     = samples[k*IW +: IW];
        w_cfg_cur = r_cfg[k];
      end
    end
  end

  assign w_term  = w_smp >> w_cfg_cur[1:0];
  assign w_add_l = w_cfg_cur[3] ? w_term : '0;
  assign w_add_r = w_cfg_cur[2] ? w_term : '0;
  assign w_sum_l = C_SUMW'(r_acc_l) + C_SUMW'(w_add_l);
  assign w_sum_r = C_SUMW'(r_acc_r) + C_SUMW'(w_add_r);
  assign w_sat_l = (w_sum_l > C_MAXV);
  assign w_sat_r = (w_sum_r > C_MAXV);
  assign w_last  = (r_idx == C_LAST);

  // Scan counter, accumulators and end-of-frame latch of the clamped mix.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_acc_l      <= '0;
      r_acc_r      <= '0;
      mix_left     <= '0;
      mix_right    <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= w_last;
      if (w_last) begin
        r_idx     <= '0;
        r_acc_l   <= '0;
        r_acc_r   <= '0;
        mix_left  <= w_sat_l ? {OW{1'b1}} : w_sum_l[OW-1:0];
        mix_right <= w_sat_r ? {OW{1'b1}} : w_sum_r[OW-1:0];
      end else begin
        r_idx   <= r_idx + C_IDXW'(1);
        r_acc_l <= w_sum_l[C_ACCW-1:0];
        r_acc_r <= w_sum_r[C_ACCW-1:0];
      end
    end
  end

  // Sticky clip flags; a saturating frame end overrides a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_left  <= 1'b0;
      clip_right <= 1'b0;
    end else begin
      if (clip_clr) begin
        clip_left  <= 1'b0;
        clip_right <= 1'b0;
      end
      if (w_last && w_sat_l) clip_left  <= 1'b1;
      if (w_last && w_sat_r) clip_right <= 1'b1;
    end
  end

  // First-order sigma-delta per side: the MSB feedback subtracts 2^OW
  // (adding 3<<OW modulo 2^(OW+2)) whenever a one is emitted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_integ_l <= C_INTEG_RST;
      r_integ_r <= C_INTEG_RST;
      dac_left  <= 1'b0;
      dac_right <= 1'b0;
    end else begin
      r_integ_l <= r_integ_l + C_DW'(mix_left)
                   + {{2{r_integ_l[C_DW-1]}}, {OW{1'b0}}};
      r_integ_r <= r_integ_r + C_DW'(mix_right)
                   + {{2{r_integ_r[C_DW-1]}}, {OW{1'b0}}};
      dac_left  <= r_integ_l[C_DW-1];
      dac_right <= r_integ_r[C_DW-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stereo_scan_mixer_dac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stereo_scan_mixer_dac
//  Description : Scoreboard bench for stereo_scan_mixer_dac. Each frame's
//                expected mix/clip values are queued as stimulus is driven
//                and compared when frame_strobe appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stereo_scan_mixer_dac;

  localparam int         NCH     = 8;
  localparam int         IW      = 8;
  localparam int         OW      = 10;
  localparam logic [7:0] CFG_RST = 8'hC0;
  localparam int         MAXV    = (1 << OW) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_ch = '0;
  logic [7:0]        cfg_din = '0;
  logic [7:0]        cfg_dout;
  logic [NCH*IW-1:0] samples = '0;
  logic              clip_clr = 1'b0;
  logic [OW-1:0]     mix_left, mix_right;
  logic              frame_strobe, clip_left, clip_right, dac_left, dac_right;

  always #5 clk = ~clk;

  stereo_scan_mixer_dac #(
    .NCH(NCH), .IW(IW), .OW(OW), .CFG_RST(CFG_RST)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_din(cfg_din), .cfg_dout(cfg_dout), .samples(samples),
    .clip_clr(clip_clr), .mix_left(mix_left), .mix_right(mix_right),
    .frame_strobe(frame_strobe), .clip_left(clip_left),
    .clip_right(clip_right), .dac_left(dac_left), .dac_right(dac_right)
  );

  typedef struct {
    int l;
    int r;
    bit cl;
    bit cr;
  } frame_t;

  frame_t     sb_q[$];
  frame_t     mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         smp[NCH];
  logic [7:0] cfg_m[NCH];
  bit         clip_ml, clip_mr;
  bit         pend_we[NCH];
  int         pend_ch[NCH];
  logic [7:0] pend_din[NCH];
  bit         pend_clr[NCH];
  bit         cnt_en = 1'b0;
  bit         watch_strobe = 1'b0;
  int         ones_l, ones_r;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Pop and compare one expected frame on every strobe.
  always @(negedge clk) begin
    if (!reset && frame_strobe === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("mix_left", 32'(mix_left), mon_e.l);
        check("mix_right", 32'(mix_right), mon_e.r);
        check("clip_left", 32'(clip_left), 32'(mon_e.cl));
        check("clip_right", 32'(clip_right), 32'(mon_e.cr));
      end
    end
  end

  task automatic clear_stim();
    for (int k = 0; k < NCH; k++) begin
      smp[k]      = 0;
      pend_we[k]  = 1'b0;
      pend_ch[k]  = 0;
      pend_din[k] = 8'h00;
      pend_clr[k] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) cfg_m[k] = CFG_RST;
    clip_ml = 1'b0;
    clip_mr = 1'b0;
  endtask

  // Schedule one config write in scan cycle cyc of the next frame.
  task automatic sched_write(input int cyc, input int ch, input logic [7:0] din);
    pend_we[cyc]  = 1'b1;
    pend_ch[cyc]  = ch;
    pend_din[cyc] = din;
  endtask

  // Drive one full frame starting at a frame boundary; queue its expectation.
  task automatic run_frame();
    frame_t e;
    int sl = 0;
    int sr = 0;
    int t;
    for (int k = 0; k < NCH; k++) begin
      t = smp[k] >> cfg_m[k][5:4];
      if (cfg_m[k][7]) sl += t;
      if (cfg_m[k][6]) sr += t;
      if (pend_clr[k]) begin
        clip_ml = 1'b0;
        clip_mr = 1'b0;
      end
      if (pend_we[k] && pend_ch[k] < NCH) cfg_m[pend_ch[k]] = {pend_din[k][7:4], 4'h0};
    end
    e.l = (sl > MAXV) ? MAXV : sl;
    e.r = (sr > MAXV) ? MAXV : sr;
    if (sl > MAXV) clip_ml = 1'b1;
    if (sr > MAXV) clip_mr = 1'b1;
    e.cl = clip_ml;
    e.cr = clip_mr;
    sb_q.push_back(e);
    for (int k = 0; k < NCH; k++) samples[k*IW +: IW] = smp[k][IW-1:0];
    for (int k = 0; k < NCH; k++) begin
      cfg_we   = pend_we[k];
      cfg_ch   = pend_ch[k][3:0];
      cfg_din  = pend_din[k];
      clip_clr = pend_clr[k];
      @(negedge clk);
      if (cnt_en) begin
        ones_l += int'(dac_left);
        ones_r += int'(dac_right);
      end
      if (watch_strobe && k < NCH - 1) check("strobe_early", 32'(frame_strobe), 32'd0);
    end
    cfg_we   = 1'b0;
    clip_clr = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      pend_we[k]  = 1'b0;
      pend_clr[k] = 1'b0;
    end
  endtask

  task automatic readback(input int ch, input logic [7:0] exp, input string tag);
    cfg_ch = ch[3:0];
    #1;
    check(tag, 32'(cfg_dout), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_stim();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check("rst_mix_left", 32'(mix_left), 32'd0);
    check("rst_mix_right", 32'(mix_right), 32'd0);
    check("rst_strobe", 32'(frame_strobe), 32'd0);
    check("rst_clip_left", 32'(clip_left), 32'd0);
    check("rst_clip_right", 32'(clip_right), 32'd0);
    check("rst_dac_left", 32'(dac_left), 32'd0);
    check("rst_dac_right", 32'(dac_right), 32'd0);
    readback(0, CFG_RST, "rst_cfg_ch0");
    readback(9, 8'h00, "rst_cfg_ch9");
    reset = 1'b0;

    // Program ch0 left-only (low nibble must be dropped), mute the rest.
    clear_stim();
    for (int k = 0; k < NCH; k++) sched_write(k, k, (k == 0) ? 8'h8F : 8'h00);
    run_frame();
    readback(0, 8'h80, "rb_ch0_lowbits");
    smp[0] = 100;
    run_frame();
    run_frame();

    // Attenuation: ch3 both sides, shift 2; out-of-range write ignored.
    clear_stim();
    sched_write(0, 0, 8'h00);
    sched_write(1, 3, 8'hE0);
    sched_write(2, 9, 8'hFF);
    run_frame();
    readback(3, 8'hE0, "rb_ch3");
    readback(9, 8'h00, "rb_ch9_ignored");
    smp[3] = 200;
    run_frame();

    // Saturation and clip flag behaviour.
    clear_stim();
    for (int k = 0; k < NCH; k++) sched_write(k, k, CFG_RST);
    run_frame();
    for (int k = 0; k < NCH; k++) smp[k] = 255;
    run_frame();
    clear_stim();
    pend_clr[2] = 1'b1;
    run_frame();
    for (int k = 0; k < NCH; k++) smp[k] = 255;
    pend_clr[NCH-1] = 1'b1;
    run_frame();

    // Write to the channel scanned in the end-of-frame cycle.
    clear_stim();
    smp[7] = 40;
    sched_write(7, 7, 8'h00);
    run_frame();
    run_frame();
    readback(7, 8'h00, "rb_ch7_collision");

    // Write ahead of the scan position takes effect in the same frame.
    clear_stim();
    smp[5] = 60;
    sched_write(2, 5, 8'h90);
    run_frame();

    // DAC density with mix_left held at 256, right side silent.
    clear_stim();
    for (int k = 0; k < NCH; k++) sched_write(k, k, (k < 2) ? 8'h80 : 8'h00);
    run_frame();
    smp[0] = 128;
    smp[1] = 128;
    repeat (16) run_frame();
    ones_l = 0;
    ones_r = 0;
    cnt_en = 1'b1;
    repeat (128) run_frame();
    cnt_en = 1'b0;
    check("dac_left_ones_256", ones_l, 256);
    check("dac_right_ones_0", ones_r, 0);

    // DAC with mix at zero settles to a constant 0.
    clear_stim();
    repeat (4) run_frame();
    ones_l = 0;
    ones_r = 0;
    cnt_en = 1'b1;
    repeat (64) run_frame();
    cnt_en = 1'b0;
    check("dac_left_zero", ones_l, 0);

    // Mid-frame reset from a saturated, clipped state.
    clear_stim();
    for (int k = 0; k < NCH; k++) begin
      smp[k] = 255;
      sched_write(k, k, (k == 2) ? 8'h40 : CFG_RST);
    end
    run_frame();
    run_frame();
    for (int k = 0; k < NCH; k++) pend_we[k] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check("mrst_mix_left", 32'(mix_left), 32'd0);
    check("mrst_mix_right", 32'(mix_right), 32'd0);
    check("mrst_strobe", 32'(frame_strobe), 32'd0);
    check("mrst_clip_left", 32'(clip_left), 32'd0);
    check("mrst_clip_right", 32'(clip_right), 32'd0);
    check("mrst_dac_left", 32'(dac_left), 32'd0);
    check("mrst_dac_right", 32'(dac_right), 32'd0);
    readback(2, CFG_RST, "mrst_cfg_ch2");
    reset = 1'b0;
    clear_stim();
    for (int k = 0; k < NCH; k++) smp[k] = 10 * (k + 1);
    watch_strobe = 1'b1;
    run_frame();
    watch_strobe = 1'b0;

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
